// File: rtl/fir_mac_filter_if.sv
// Sample/result handshake and coefficient-load bus for the heart-rate FIR filter.
// The master modport drives samples and coefficients; the filter uses the slave modport.
interface fir_mac_filter_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned TAPS   = 31,
    parameter int unsigned COEF_W = 16
);
    localparam int unsigned ADDR_W = $clog2(TAPS);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sample;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_sample;
    logic              busy;
    logic              sat;

    modport master (
        output in_valid, in_sample, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_sample, busy, sat
    );

    modport slave (
        input  in_valid, in_sample, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_sample, busy, sat
    );
endinterface

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one signed MAC per clock over a TAPS-deep delay line, then a
// round-half-up / saturate step producing one unsigned result per accepted sample.
module fir_mac_filter #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned TAPS      = 31,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned COEF_FRAC = 14
) (
    input  logic             clk,
    input  logic             reset,
    fir_mac_filter_if.slave  bus
);
    localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS) + 1;
    localparam int unsigned TAP_W  = $clog2(TAPS);
    localparam int unsigned PROD_W = COEF_W + DATA_W + 1;

    localparam logic [COEF_W-1:0] COEF_ONE  = COEF_W'(1) << COEF_FRAC;
    localparam logic [ACC_W-1:0]  HALF_LSB  = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic [DATA_W-1:0] OUT_MAX   = '1;

    typedef enum logic [1:0] {StIdle, StMac, StRound} state_e;

    state_e                   state_q, state_d;
    logic [DATA_W-1:0]        x_q    [TAPS];
    logic [DATA_W-1:0]        x_d    [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [TAP_W-1:0]         tap_q, tap_d;
    logic [DATA_W-1:0]        out_sample_q, out_sample_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sat_q, sat_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  res;

    // Samples are zero-extended so they always multiply as non-negative values.
    assign prod = PROD_W'(coef_q[tap_q]) * PROD_W'($signed({1'b0, x_q[tap_q]}));
    assign rnd  = acc_q + $signed(HALF_LSB);
    assign res  = rnd >>> COEF_FRAC;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        coef_d       = coef_q;
        acc_d        = acc_q;
        tap_d        = tap_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        sat_d        = sat_q;

        unique case (state_q)
            StIdle: begin
                // Coefficient write lands at this edge, so a same-cycle sample sees it.
                if (bus.coef_we && (32'(bus.coef_addr) < TAPS)) begin
                    coef_d[bus.coef_addr] = bus.coef_data;
                end
                if (bus.in_valid) begin
                    for (int k = TAPS - 1; k >= 1; k--) begin
                        x_d[k] = x_q[k-1];
                    end
                    x_d[0]  = bus.in_sample;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + ACC_W'(prod);
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    state_d = StRound;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StRound: begin
                out_valid_d = 1'b1;
                if (res[ACC_W-1]) begin
                    out_sample_d = '0;
                    sat_d        = 1'b1;
                end else if (|res[ACC_W-2:DATA_W]) begin
                    out_sample_d = OUT_MAX;
                    sat_d        = 1'b1;
                end else begin
                    out_sample_d = res[DATA_W-1:0];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            tap_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            sat_q        <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= (k == 0) ? COEF_ONE : '0;
            end
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            tap_q        <= tap_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            sat_q        <= sat_d;
            x_q          <= x_d;
            coef_q       <= coef_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign bus.sat        = sat_q;
endmodule
